aes_byte_packer: RTL and testbench

Byte-serial front end for the combinational AES-128 encrypt core. It accepts plaintext one byte per handshake and assembles 16 bytes into a 128-bit block. It holds the block on a valid/ready output that drives the core's `text` input. With CBC enabled, it XORs the assembled block with a chaining value (an IV, or the core's previous ciphertext fed back) before presenting it.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_byte_packer.sv | 113 +++++++++++
 tb/tb_aes_byte_packer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared definitions for the AES byte-serial front end.
//               Block/byte widths, packer state encoding and the byte-lane
//               index helper that maps a byte counter to its bit position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_BYTES = 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pk_state_t;

    // Low bit of the byte lane for byte index idx. Byte 0 occupies
    // [127:120] (MSB-first, the core's byte order), so the lane LSB is
    // 8*(15-idx); {~idx, 3'b000} is that product without a multiplier.
    function automatic logic [6:0] lane_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_byte_packer.sv
// ============================================================================
// Module      : aes_byte_packer
// Description : Byte-serial plaintext packer for the combinational AES-128
//               encrypt core. Accepts one byte per s_valid/s_ready handshake,
//               assembles 16 bytes MSB-first into a 128-bit block and holds it
//               on a blk_valid/blk_ready interface feeding the core's text
//               input.
//               Optional CBC (macro AES_CBC_EN): the held block is XORed with
//               a chain register loaded from iv (iv_load) or from the core's
//               previous ciphertext (chain_valid); release is gated until a
//               chain value has been loaded since the last block handshake.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               s_valid/s_ready/s_data    - byte input handshake
//               clr                - synchronous abort of partial/held block
//               blk_valid/blk_ready/blk_text - block output handshake
//               iv, iv_load, chain_in, chain_valid - CBC chaining (AES_CBC_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_byte_packer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 clr,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [AES_BLK_W-1:0] blk_text
`ifdef AES_CBC_EN
    ,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic                 iv_load,
    input  logic [AES_BLK_W-1:0] chain_in,
    input  logic                 chain_valid
`endif
);

    pk_state_t              r_state;
    logic [3:0]             r_cnt;
    logic [AES_BLK_W-1:0]   r_data;
    logic [6:0]             w_lsb;

    assign w_lsb   = lane_lsb(r_cnt);
    // Readiness depends on state alone so there is no path from blk_ready.
    assign s_ready = (r_state == ST_FILL);

`ifdef AES_CBC_EN
    logic [AES_BLK_W-1:0]   r_chain;
    logic                   r_chain_ok;
    logic                   w_hs;

    assign blk_valid = (r_state == ST_HOLD) && r_chain_ok;
    assign blk_text  = r_data ^ r_chain;
    // clr suppresses the handshake, so it must not consume the chain value.
    assign w_hs      = blk_valid && blk_ready && !clr;

    // Chain register is untouched by clr; a load in the handshake cycle
    // takes precedence over the handshake clearing chain_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain    <= '0;
            r_chain_ok <= 1'b0;
        end else if (iv_load) begin
            r_chain    <= iv;
            r_chain_ok <= 1'b1;
        end else if (chain_valid) begin
            r_chain    <= chain_in;
            r_chain_ok <= 1'b1;
        end else if (w_hs) begin
            r_chain_ok <= 1'b0;
        end
    end
`else
    assign blk_valid = (r_state == ST_HOLD);
    assign blk_text  = r_data;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= ST_FILL;
            r_cnt   <= 4'd0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (s_valid) begin
                        r_data[w_lsb +: 8] <= s_data;
                        // 4-bit counter wraps 15 -> 0 on the last byte.
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (blk_valid && blk_ready) begin
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_byte_packer.sv
// ============================================================================
// Module      : tb_aes_byte_packer
// Description : Self-checking bench for aes_byte_packer. Directed stimulus
//               in one initial block; expected blocks are queued when their
//               bytes are driven and compared when the packer releases them.
//               Builds with or without AES_CBC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_byte_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         clr;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_text;
`ifdef AES_CBC_EN
    logic [127:0] iv;
    logic         iv_load;
    logic [127:0] chain_in;
    logic         chain_valid;
`endif

    int           checks   = 0;
    int           errors   = 0;
    int           hs_count = 0;
    logic [127:0] sb_q[$];
    logic [127:0] exp_blk;
    logic [127:0] mon_exp;

    always #5 clk = ~clk;

    aes_byte_packer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .clr         (clr),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_text    (blk_text)
`ifdef AES_CBC_EN
        ,
        .iv          (iv),
        .iv_load     (iv_load),
        .chain_in    (chain_in),
        .chain_valid (chain_valid)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive 16 bytes MSB-first back to back; blk_valid must still be low
    // after the 15th byte and high right after the 16th.
    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = blk[(15-i)*8 +: 8];
            tick();
            if (i == 14) chk("valid_before_16th", 128'(blk_valid), 128'd0);
        end
        s_valid = 1'b0;
        chk("valid_after_16th", 128'(blk_valid), 128'd1);
    endtask

    // With CBC built in, release needs a fresh chain value; load zero so the
    // plain-path tests see blk_text equal to the assembled data.
    task automatic arm();
`ifdef AES_CBC_EN
        chain_in    = '0;
        chain_valid = 1'b1;
        tick();
        chain_valid = 1'b0;
`endif
    endtask

    // Scoreboard: a handshake is judged at the negedge before the edge that
    // completes it (rst and clr suppress it).
    always @(negedge clk) begin
        if (!rst && !clr && blk_valid && blk_ready) begin
            hs_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_block observed=%h expected=none", blk_text);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("block_text", blk_text, mon_exp);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        clr       = 1'b0;
        blk_ready = 1'b0;
`ifdef AES_CBC_EN
        iv          = '0;
        iv_load     = 1'b0;
        chain_in    = '0;
        chain_valid = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_s_ready",   128'(s_ready),   128'd1);
        chk("rst_blk_valid", 128'(blk_valid), 128'd0);
        chk("rst_blk_text",  blk_text,        128'd0);

        // Basic block, consumer always ready
        blk_ready = 1'b1;
        arm();
        exp_blk = 128'h00112233445566778899aabbccddeeff;
        sb_q.push_back(exp_blk);
        send_block(exp_blk);
        tick();
        chk("t1_s_ready_after_hs", 128'(s_ready),   128'd1);
        chk("t1_valid_after_hs",   128'(blk_valid), 128'd0);
        chk("t1_hs_count",         128'(hs_count),  128'd1);

        // Back-pressure: hold for 10 cycles while bytes are offered
        blk_ready = 1'b0;
        arm();
        exp_blk = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        sb_q.push_back(exp_blk);
        send_block(exp_blk);
        s_valid = 1'b1;
        s_data  = 8'hee;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid",   128'(blk_valid), 128'd1);
            chk("t2_hold_s_ready", 128'(s_ready),   128'd0);
            chk("t2_hold_text",    blk_text,        exp_blk);
        end
        s_valid   = 1'b0;
        blk_ready = 1'b1;
        tick();
        chk("t2_hs_count", 128'(hs_count), 128'd2);

        // Abort after 7 bytes; clr also beats a byte offered in its cycle
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h3c + 8'(i);
            tick();
        end
        clr    = 1'b1;
        s_data = 8'h77;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        chk("t3_clr_s_ready", 128'(s_ready),   128'd1);
        chk("t3_clr_valid",   128'(blk_valid), 128'd0);
`ifndef AES_CBC_EN
        chk("t3_clr_text",    blk_text,        128'd0);
`endif
        arm();
        exp_blk = {16{8'ha5}};
        sb_q.push_back(exp_blk);
        send_block(exp_blk);
        tick();
        chk("t3_hs_count", 128'(hs_count), 128'd3);

        // Reset while holding with blk_ready high: no handshake
        blk_ready = 1'b0;
        arm();
        send_block(128'hdeadbeefcafef00d0badc0de12345678);
        rst       = 1'b1;
        blk_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_valid",   128'(blk_valid), 128'd0);
        chk("t4_rst_s_ready", 128'(s_ready),   128'd1);
        chk("t4_rst_text",    blk_text,        128'd0);
        chk("t4_rst_hs",      128'(hs_count),  128'd3);
        // Counter restarted at 0: a fresh 16 bytes form an aligned block
        arm();
        exp_blk = 128'h0123456789abcdeffedcba9876543210;
        sb_q.push_back(exp_blk);
        send_block(exp_blk);
        tick();
        chk("t4_hs_count", 128'(hs_count), 128'd4);

`ifdef AES_CBC_EN
        // IV load then first CBC block
        iv      = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        exp_blk = 128'h00112233445566778899aabbccddeeff ^ iv;
        chk("t5_expected_model", exp_blk, 128'h00102030405060708090a0b0c0d0e0f0);
        sb_q.push_back(exp_blk);
        send_block(128'h00112233445566778899aabbccddeeff);
        tick();
        chk("t5_hs_count", 128'(hs_count), 128'd5);

        // Next block waits for the ciphertext feedback
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h40 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_gated_valid",   128'(blk_valid), 128'd0);
            chk("t6_gated_s_ready", 128'(s_ready),   128'd0);
            tick();
        end
        chain_in    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        chain_valid = 1'b1;
        sb_q.push_back(128'h404142434445464748494a4b4c4d4e4f ^ chain_in);
        tick();
        chain_valid = 1'b0;
        chk("t6_released", 128'(blk_valid), 128'd1);
        tick();
        chk("t6_hs_count", 128'(hs_count), 128'd6);
        chk("t6_chain_consumed", 128'(blk_valid), 128'd0);
`endif

        tick();
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
